// File: rtl/four_bit_adder.sv
// Registered 4-bit ripple-carry adder with carry-in, carry-out and signed overflow.
// Each valid input beat produces one result exactly one cycle later.
module four_bit_adder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    input  logic       in_valid,
    output logic [3:0] s,
    output logic       cout,
    output logic       ovf,
    output logic       out_valid
);

    logic [4:0] carry;
    logic [3:0] sum_d;
    logic [3:0] s_q;
    logic       cout_q;
    logic       ovf_q;
    logic       out_valid_q;

    assign carry[0] = cin;

    // One full adder per bit; the carry ripples from bit 0 upward.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_fa
            logic prop;
            assign prop          = a[gi] ^ b[gi];
            assign sum_d[gi]     = prop ^ carry[gi];
            assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & prop);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_q         <= 4'd0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                s_q    <= sum_d;
                cout_q <= carry[4];
                // Signed overflow: carry into the sign bit differs from carry out of it.
                ovf_q  <= carry[3] ^ carry[4];
            end
        end
    end

    assign s         = s_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_four_bit_adder.sv
// Directed and exhaustive checks of four_bit_adder against hand-computed and
// arithmetic reference values, sampled 1 time unit after each rising edge.
module tb_four_bit_adder;

    logic       clk;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic       in_valid;
    logic [3:0] s;
    logic       cout;
    logic       ovf;
    logic       out_valid;

    int n_checks;
    int n_pass;

    four_bit_adder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .in_valid  (in_valid),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    endtask

    // Drive one beat, then sample the registered outputs just after the edge.
    task automatic step(input logic rn, input logic v, input logic [3:0] ta,
                        input logic [3:0] tb, input logic tc);
        rst_n    = rn;
        in_valid = v;
        a        = ta;
        b        = tb;
        cin      = tc;
        @(posedge clk);
        #1;
    endtask

    // Directed vector: inputs, then hand-computed s, cout, ovf.
    task automatic directed(input string tag, input logic [3:0] ta, input logic [3:0] tb,
                            input logic tc, input logic [3:0] es, input logic ec,
                            input logic eo);
        step(1'b1, 1'b1, ta, tb, tc);
        $display("txn %s: a=%0d b=%0d cin=%0d -> s=%0d cout=%0d ovf=%0d vld=%0d",
                 tag, ta, tb, tc, s, cout, ovf, out_valid);
        check({tag, ".s"},    {1'b0, s},    {1'b0, es});
        check({tag, ".cout"}, {4'd0, cout}, {4'd0, ec});
        check({tag, ".ovf"},  {4'd0, ovf},  {4'd0, eo});
        check({tag, ".vld"},  {4'd0, out_valid}, 5'd1);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n = 1'b0; in_valid = 1'b0; a = 4'd0; b = 4'd0; cin = 1'b0;

        // Reset state
        repeat (2) step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        check("rst.s",   {1'b0, s}, 5'd0);
        check("rst.cout",{4'd0, cout}, 5'd0);
        check("rst.ovf", {4'd0, ovf}, 5'd0);
        check("rst.vld", {4'd0, out_valid}, 5'd0);

        // Released but no valid input: still no result
        step(1'b1, 1'b0, 4'd3, 4'd3, 1'b0);
        check("idle.vld", {4'd0, out_valid}, 5'd0);
        check("idle.s",   {1'b0, s}, 5'd0);

        directed("cin_only", 4'd0,  4'd0,  1'b1, 4'd1,  1'b0, 1'b0);
        directed("wrap",     4'd15, 4'd1,  1'b0, 4'd0,  1'b1, 1'b0);
        directed("posovf",   4'd7,  4'd1,  1'b0, 4'd8,  1'b0, 1'b1);
        directed("max",      4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 1'b0);
        directed("negovf",   4'd8,  4'd8,  1'b0, 4'd0,  1'b1, 1'b1);
        directed("nine",     4'd4,  4'd5,  1'b0, 4'd9,  1'b0, 1'b1);

        // Hold: s stays 9 while in_valid is low
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 4'd1, 4'd1, 1'b1);
            $display("txn hold%0d: s=%0d vld=%0d", i, s, out_valid);
            check("hold.s",    {1'b0, s}, 5'd9);
            check("hold.vld",  {4'd0, out_valid}, 5'd0);
            check("hold.ovf",  {4'd0, ovf}, 5'd1);
        end

        // Reset wins over a simultaneous valid beat
        step(1'b0, 1'b1, 4'd15, 4'd1, 1'b0);
        $display("txn rst_vs_valid: s=%0d cout=%0d ovf=%0d vld=%0d", s, cout, ovf, out_valid);
        check("rstpri.s",    {1'b0, s}, 5'd0);
        check("rstpri.cout", {4'd0, cout}, 5'd0);
        check("rstpri.ovf",  {4'd0, ovf}, 5'd0);
        check("rstpri.vld",  {4'd0, out_valid}, 5'd0);

        // Exhaustive sweep, back-to-back beats
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    int sum_u;
                    int sum_s;
                    int sa;
                    int sb;
                    logic [4:0] exp_u;
                    logic exp_o;
                    sum_u = ia + ib + ic;
                    sa = (ia > 7) ? ia - 16 : ia;
                    sb = (ib > 7) ? ib - 16 : ib;
                    sum_s = sa + sb + ic;
                    exp_u = sum_u[4:0];
                    exp_o = (sum_s > 7) || (sum_s < -8);
                    step(1'b1, 1'b1, ia[3:0], ib[3:0], ic[0]);
                    $display("txn sweep: a=%0d b=%0d cin=%0d -> cout:s=%0d ovf=%0d",
                             ia, ib, ic, {cout, s}, ovf);
                    check("sweep.sum", {cout, s}, exp_u);
                    check("sweep.ovf", {4'd0, ovf}, {4'd0, exp_o});
                    check("sweep.vld", {4'd0, out_valid}, 5'd1);
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/four_bit_adder.md
FOUR_BIT_ADDER -- requirements
Module: four_bit_adder

Interface
REQ-001 The block SHALL have no parameters; operand width SHALL be fixed at 4 bits.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low, sampled on the rising edge of clk.
REQ-004 The block SHALL have port a, input, 4 bits: unsigned operand A.
REQ-005 The block SHALL have port b, input, 4 bits: unsigned operand B.
REQ-006 The block SHALL have port cin, input, 1 bit: carry-in, weight 1.
REQ-007 The block SHALL have port in_valid, input, 1 bit: a/b/cin are valid this cycle.
REQ-008 The block SHALL have port s, output, 4 bits: registered sum bits [3:0].
REQ-009 The block SHALL have port cout, output, 1 bit: registered carry-out, weight 16.
REQ-010 The block SHALL have port ovf, output, 1 bit: registered two's-complement overflow flag.
REQ-011 The block SHALL have port out_valid, output, 1 bit: s/cout/ovf hold a new result this cycle.

Function
REQ-012 The block SHALL compute {cout, s} = a + b + cin as a 5-bit unsigned result, with no truncation beyond bit 4.
REQ-013 The adder SHALL be a 4-stage ripple-carry chain of full adders, where s[i] = a[i]^b[i]^c[i], c[i+1] = a[i]&b[i] | c[i]&(a[i]^b[i]), c[0] = cin and cout = c[4].
REQ-014 The block SHALL set ovf = c[3] ^ c[4], flagging signed overflow when operands are interpreted as 4-bit two's complement.
REQ-015 On a rising edge with rst_n=1 and in_valid=1, s, cout and ovf SHALL register the result of the current a/b/cin, and out_valid SHALL be set to 1.
REQ-016 Latency SHALL be exactly 1 cycle from the sampled inputs to the registered outputs, with throughput of one result per cycle.
REQ-017 On a rising edge with rst_n=1 and in_valid=0, s, cout and ovf SHALL hold their previous values, and out_valid SHALL be set to 0.
REQ-018 Wrap-around: a sum of 16 or more SHALL wrap s modulo 16 and set cout=1 (e.g. 15+1+0 gives s=0, cout=1).
REQ-019 Maximum case: 15+15+1 SHALL give s=15 and cout=1.
REQ-020 There SHALL be no combinational path from any input to any output.

Reset
REQ-021 When rst_n=0 at a rising edge, s SHALL be set to 0, cout to 0, ovf to 0 and out_valid to 0, regardless of in_valid.
REQ-022 Reset SHALL take priority over a simultaneous in_valid=1, and the in-flight result SHALL be discarded.
REQ-023 The first result after reset release SHALL come from the first edge with rst_n=1 and in_valid=1, and SHALL appear after that edge.

Verification
REQ-024 The bench SHALL check that a=0, b=0, cin=1, in_valid=1 gives, one cycle later, s=1, cout=0, ovf=0, out_valid=1.
REQ-025 The bench SHALL check that a=15, b=1, cin=0 gives s=0, cout=1, ovf=0.
REQ-026 The bench SHALL check that a=7, b=1, cin=0 gives s=8, cout=0, ovf=1.
REQ-027 The bench SHALL check that a=15, b=15, cin=1 gives s=15, cout=1, ovf=0.
REQ-028 The bench SHALL check that after a valid result of s=9, driving in_valid=0 for 3 cycles keeps s=9 and gives out_valid=0.
REQ-029 The bench SHALL check that rst_n=0 asserted on the same edge as in_valid=1 with a=15, b=1 gives all outputs 0 after that edge.
REQ-030 The bench SHALL compare an exhaustive sweep of all 512 a/b/cin combinations against a+b+cin with 1-cycle latency.
